// File: rtl/wb_data_ram_slave_pkg.sv
// Shared definitions for the Wishbone data-RAM slave: bus widths and the
// response FSM state encoding.
package wb_data_ram_slave_pkg;

    localparam int WB_AW = 32;          // Wishbone byte-address width
    localparam int WB_DW = 32;          // Wishbone data width
    localparam int WB_SW = WB_DW / 8;   // byte lanes per word

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,   // waiting for cyc & stb
        ST_WAIT = 2'b01,   // counting wait states
        ST_RESP = 2'b10,   // ack/err decision and memory write edge
        ST_DEAD = 2'b11    // guard cycle so a lingering stb is not re-accepted
    } state_t;

    // Counter preload for a given number of wait states (0 means no WAIT state).
    function automatic logic [2:0] wait_load(input int wait_states);
        return (wait_states == 0) ? 3'd0 : 3'(wait_states - 1);
    endfunction

endpackage

// File: rtl/wb_sram_core.sv
// Behavioural single-port synchronous RAM, 2**AW words of 32 bits, with a
// per-byte write enable and a registered read port. Kept behind this small
// interface so it can be swapped for a vendor macro.
module wb_sram_core
    import wb_data_ram_slave_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [WB_SW-1:0] i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WB_DW-1:0] i_wdata,
    output logic [WB_DW-1:0] o_rdata
);

    logic [WB_DW-1:0] r_mem [2**AW];
    logic [WB_DW-1:0] r_rdata;

    // Byte-lane write and read-before-write registered read on the enabled edge.
    // NOTE: the array has no reset; clearing every word would turn the RAM into
    // flops and block mapping onto a real memory macro.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < WB_SW; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_data_ram_slave.sv
// Wishbone B3 classic-cycle slave in front of a word-organised data SRAM.
// Decodes a 4*2**AW byte window at BASE_ADDR, inserts WAIT_STATES wait cycles,
// then terminates with a single-cycle ack (in range) or err (out of range).
module wb_data_ram_slave
    import wb_data_ram_slave_pkg::*;
#(
    parameter int          AW          = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [WB_AW-1:0] wb_adr_i,
    input  logic [WB_SW-1:0] wb_sel_i,
    input  logic [WB_DW-1:0] wb_dat_i,
    output logic [WB_DW-1:0] wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o
);

    localparam logic [2:0] CNT_LOAD = wait_load(WAIT_STATES);

    // Address decode of the live request
    logic [WB_AW-1:0] w_off;
    logic             w_in_range;
    logic [AW-1:0]    w_word_idx;
    logic             w_req;
    logic             w_unused_low;

    assign w_req        = wb_cyc_i & wb_stb_i;
    assign w_off        = wb_adr_i - BASE_ADDR;
    assign w_in_range   = (w_off[WB_AW-1:AW+2] == '0) && (wb_adr_i >= BASE_ADDR);
    assign w_word_idx   = w_off[AW+1:2];
    assign w_unused_low = ^w_off[1:0];   // byte offset within a word is ignored

    // State and captured request
    state_t           r_state;
    logic [2:0]       r_cnt;
    logic             r_we;
    logic [AW-1:0]    r_idx;
    logic [WB_SW-1:0] r_sel;
    logic [WB_DW-1:0] r_wdat;
    logic             r_in_range;
    logic             r_ack;
    logic             r_err;
    logic [WB_DW-1:0] r_dat_o;

    // Next-state and control decode
    state_t           w_state_nxt;
    logic [2:0]       w_cnt_nxt;
    logic             w_capture;
    logic             w_ack_nxt;
    logic             w_err_nxt;
    logic             w_wr;
    logic             w_rd;

    // RAM interface
    logic             w_ram_en;
    logic [WB_SW-1:0] w_ram_we;
    logic [AW-1:0]    w_ram_addr;
    logic [WB_DW-1:0] w_ram_rdata;

    // FSM next-state, counter and termination decode
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_wr        = 1'b0;
        w_rd        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_capture = 1'b1;
                    w_rd      = w_in_range;
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_rd = r_in_range;
                    if (r_cnt == 3'd0) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_DEAD;
                if (wb_cyc_i) begin
                    if (r_in_range) begin
                        w_ack_nxt = 1'b1;
                        w_wr      = r_we;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // In IDLE the RAM looks at the live address so a zero-wait read is ready
    // by RESP; afterwards it follows the captured word index.
    assign w_ram_addr = (r_state == ST_IDLE) ? w_word_idx : r_idx;
    assign w_ram_en   = w_rd | w_wr;
    assign w_ram_we   = {WB_SW{w_wr}} & r_sel;

    // FSM state, request capture and registered bus outputs
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_sel      <= '0;
            r_wdat     <= '0;
            r_in_range <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_dat_o    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            if (w_capture) begin
                r_we       <= wb_we_i;
                r_idx      <= w_word_idx;
                r_sel      <= wb_sel_i;
                r_wdat     <= wb_dat_i;
                r_in_range <= w_in_range;
            end
            if (w_ack_nxt && !r_we) begin
                r_dat_o <= w_ram_rdata;
            end
        end
    end

    wb_sram_core #(
        .AW (AW)
    ) u_sram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdat),
        .o_rdata (w_ram_rdata)
    );

    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_dat_o = r_dat_o;

endmodule
